// File: rtl/mult_cell_pkg.sv
// Shared definitions for the pipelined multiply cell.
//   OP_W : width of the operation code
//   op_e : operation codes
//          OP_MUL    - low word of the product
//          OP_MULXUU - high word, both operands unsigned
//          OP_MULXSU - high word, a signed and b unsigned
//          OP_MULXSS - high word, both operands signed
package mult_cell_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } op_e;

endpackage

// File: rtl/mult_cell_pp.sv
// Registered HALF_W x HALF_W unsigned multiplier with a clock enable.
// Intended to map onto one dedicated DSP block.
//   clk : clock
//   en  : load enable; p holds its value while low
//   a   : unsigned multiplicand
//   b   : unsigned multiplier
//   p   : registered 2*HALF_W product
module mult_cell_pp #(
    parameter int unsigned HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [HALF_W-1:0]     a,
    input  logic [HALF_W-1:0]     b,
    output logic [2*HALF_W-1:0]   p
);

    localparam int unsigned P_W = 2 * HALF_W;

    // No reset: the valid bit travelling beside this register qualifies it.
    always_ff @(posedge clk) begin
        if (en) begin
            p <= P_W'(a) * P_W'(b);
        end
    end

endmodule

// File: rtl/mult_cell_pipe.sv
// Pipelined DATA_W x DATA_W multiplier with elastic valid/ready handshake and flush.
// S1 registers operands, S2 forms four half-width partial products, S3 sums them with
// signed correction and selects the result word, optional S4 is an output register.
//   clk        : clock
//   reset      : synchronous active-high reset
//   in_valid   : request
//   in_ready   : request accepted this cycle when in_valid is also high
//   in_op      : operation code (see mult_cell_pkg::op_e)
//   in_a, in_b : operands
//   in_tag     : sideband tag returned with the result
//   flush      : kill every in-flight operation, including a same-cycle request
//   out_valid  : result available
//   out_ready  : consumer accepts the result
//   out_result : selected product word
//   out_tag    : tag of the returned operation
//   busy       : any stage holds a valid operation
// DATA_W must be even and at least 8.
module mult_cell_pipe
    import mult_cell_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned OUT_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned PROD_W = 2 * DATA_W;

    // A stalled output freezes the whole pipe, so bubbles are kept rather than squeezed.
    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // ---------------------------------------------------------------- S1: operands
    logic              v1_q;
    logic [DATA_W-1:0] a1_q;
    logic [DATA_W-1:0] b1_q;
    op_e               op1_q;
    logic [TAG_W-1:0]  tag1_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v1_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            a1_q   <= in_a;
            b1_q   <= in_b;
            op1_q  <= op_e'(in_op);
            tag1_q <= in_tag;
        end
    end

    // ---------------------------------------------------------------- S2: partial products
    logic                v2_q;
    op_e                 op2_q;
    logic [TAG_W-1:0]    tag2_q;
    logic [DATA_W:0]     corr2_q;
    logic [DATA_W-1:0]   pp_ll;
    logic [DATA_W-1:0]   pp_lh;
    logic [DATA_W-1:0]   pp_hl;
    logic [DATA_W-1:0]   pp_hh;

    logic                sub_b;
    logic                sub_a;
    logic [DATA_W:0]     corr_d;

    // Signed correction in the high half: a negative signed a contributes -b<<DATA_W, a
    // negative signed b contributes -a<<DATA_W. Both terms are summed here so S3 only
    // needs one subtraction.
    always_comb begin
        sub_b  = ((op1_q == OP_MULXSU) || (op1_q == OP_MULXSS)) && a1_q[DATA_W-1];
        sub_a  = (op1_q == OP_MULXSS) && b1_q[DATA_W-1];
        corr_d = (sub_b ? {1'b0, b1_q} : '0) + (sub_a ? {1'b0, a1_q} : '0);
    end

    mult_cell_pp #(
        .HALF_W (HALF_W)
    ) u_pp_ll (
        .clk (clk),
        .en  (adv),
        .a   (a1_q[HALF_W-1:0]),
        .b   (b1_q[HALF_W-1:0]),
        .p   (pp_ll)
    );

    mult_cell_pp #(
        .HALF_W (HALF_W)
    ) u_pp_lh (
        .clk (clk),
        .en  (adv),
        .a   (a1_q[HALF_W-1:0]),
        .b   (b1_q[DATA_W-1:HALF_W]),
        .p   (pp_lh)
    );

    mult_cell_pp #(
        .HALF_W (HALF_W)
    ) u_pp_hl (
        .clk (clk),
        .en  (adv),
        .a   (a1_q[DATA_W-1:HALF_W]),
        .b   (b1_q[HALF_W-1:0]),
        .p   (pp_hl)
    );

    mult_cell_pp #(
        .HALF_W (HALF_W)
    ) u_pp_hh (
        .clk (clk),
        .en  (adv),
        .a   (a1_q[DATA_W-1:HALF_W]),
        .b   (b1_q[DATA_W-1:HALF_W]),
        .p   (pp_hh)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v2_q <= 1'b0;
        end else if (adv) begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            op2_q   <= op1_q;
            tag2_q  <= tag1_q;
            corr2_q <= corr_d;
        end
    end

    // ---------------------------------------------------------------- S3: sum and select
    logic              v3_q;
    logic [DATA_W-1:0] res3_q;
    logic [TAG_W-1:0]  tag3_q;

    logic [DATA_W:0]   mid_sum;
    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] word_d;

    // Everything wraps modulo 2^PROD_W, which is exactly two's-complement behaviour.
    always_comb begin
        mid_sum = {1'b0, pp_lh} + {1'b0, pp_hl};
        prod    = PROD_W'(pp_ll)
                + (PROD_W'(mid_sum) << HALF_W)
                + (PROD_W'(pp_hh) << DATA_W)
                - (PROD_W'(corr2_q) << DATA_W);
        word_d  = (op2_q == OP_MUL) ? prod[DATA_W-1:0] : prod[PROD_W-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v3_q <= 1'b0;
        end else if (adv) begin
            v3_q <= v2_q;
        end
    end

    // Reset to zero because this is the output register when OUT_REG is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            res3_q <= '0;
            tag3_q <= '0;
        end else if (adv) begin
            res3_q <= word_d;
            tag3_q <= tag2_q;
        end
    end

    // ---------------------------------------------------------------- S4: optional output
    if (OUT_REG != 0) begin : g_out_reg
        logic              v4_q;
        logic [DATA_W-1:0] res4_q;
        logic [TAG_W-1:0]  tag4_q;

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                v4_q <= 1'b0;
            end else if (adv) begin
                v4_q <= v3_q;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                res4_q <= '0;
                tag4_q <= '0;
            end else if (adv) begin
                res4_q <= res3_q;
                tag4_q <= tag3_q;
            end
        end

        assign out_valid  = v4_q;
        assign out_result = res4_q;
        assign out_tag    = tag4_q;
        assign busy       = v1_q | v2_q | v3_q | v4_q;
    end else begin : g_no_out_reg
        assign out_valid  = v3_q;
        assign out_result = res3_q;
        assign out_tag    = tag3_q;
        assign busy       = v1_q | v2_q | v3_q;
    end

endmodule

// File: tb/tb_mult_cell_pipe.sv
// Self-checking bench for mult_cell_pipe: directed cases plus randomized traffic checked
// against a scoreboard fed by a plain signed/unsigned arithmetic model.
module tb_mult_cell_pipe;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned OUT_REG = 1;
    localparam int unsigned LAT     = 3 + OUT_REG;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    mult_cell_pipe #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .OUT_REG (OUT_REG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    int first_fire = -1;
    int last_fire  = -1;

    logic [DATA_W-1:0] q_res[$];
    logic [TAG_W-1:0]  q_tag[$];

    // Reference: extend each operand by its signedness and multiply exactly.
    function automatic logic [DATA_W-1:0] model(input logic [1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W+1:0] ea;
        logic signed [2*DATA_W+1:0] eb;
        logic signed [2*DATA_W+1:0] p;
        logic a_signed;
        logic b_signed;
        a_signed = (op >= 2'd2);
        b_signed = (op == 2'd3);
        ea = {{(DATA_W+2){a_signed & a[DATA_W-1]}}, a};
        eb = {{(DATA_W+2){b_signed & b[DATA_W-1]}}, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Inputs are set at posedge+1; settle, score the cycle, then advance one edge.
    task automatic tick();
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q_res.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("sb_result", 64'(out_result), 64'(q_res.pop_front()));
                chk("sb_tag", 64'(out_tag), 64'(q_tag.pop_front()));
            end
            n_out++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        if (reset || flush) begin
            q_res.delete();
            q_tag.delete();
        end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
            q_res.push_back(model(in_op, in_a, in_b));
            q_tag.push_back(in_tag);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_rand_in();
        int sel;
        in_op  = 2'($urandom_range(0, 3));
        in_tag = TAG_W'($urandom);
        sel = $urandom_range(0, 7);
        in_a = (sel == 0) ? '1 : (sel == 1) ? {1'b1, {(DATA_W-1){1'b0}}} : DATA_W'($urandom);
        sel = $urandom_range(0, 7);
        in_b = (sel == 0) ? '1 : (sel == 1) ? {1'b1, {(DATA_W-1){1'b0}}} : DATA_W'($urandom);
    endtask

    task automatic run_one(input string name, input logic [1:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] exp);
        int lat;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(LAT));
        chk({name, "_result"}, 64'(out_result), 64'(exp));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
        tick();
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [DATA_W-1:0] held_res;
    logic [TAG_W-1:0]  held_tag;
    int                n_before;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        // Directed values.
        run_one("mul_3x5", 2'd0, 32'h0000_0003, 32'h0000_0005, 5'h0b, 32'h0000_000F);
        run_one("mulxss_m1x2", 2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'h11, 32'hFFFF_FFFF);
        run_one("mulxuu_m1x2", 2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5'h12, 32'h0000_0001);
        run_one("mulxsu_min", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'h13, 32'h8000_0000);
        run_one("mul_ffxff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h14, 32'h0000_0001);
        run_one("mulxuu_ffxff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h15, 32'hFFFF_FFFE);
        run_one("mulxss_ffxff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h16, 32'h0000_0000);

        // Back-to-back stream of 8.
        n_out = 0;
        first_fire = -1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            set_rand_in();
            tick();
        end
        drain(8);
        chk("stream_count", 64'(n_out), 64'd8);
        chk("stream_consecutive", 64'(last_fire - first_fire), 64'd7);
        chk("stream_sb_empty", 64'(q_res.size()), 64'd0);

        // Stall with a stream pending.
        for (int i = 0; i < LAT; i++) begin
            in_valid = 1'b1;
            set_rand_in();
            tick();
        end
        out_ready = 1'b0;
        set_rand_in();
        #1;
        chk("stall_setup_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        held_res = out_result;
        held_tag = out_tag;
        for (int i = 0; i < 5; i++) begin
            set_rand_in();
            tick();
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
            chk("stall_hold_result", 64'(out_result), 64'(held_res));
            chk("stall_hold_tag", 64'(out_tag), 64'(held_tag));
            chk("stall_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rand_in();
            tick();
        end
        drain(10);
        chk("stall_sb_empty", 64'(q_res.size()), 64'd0);

        // Flush with three in flight and a same-cycle request.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_rand_in();
            tick();
        end
        flush = 1'b1;
        set_rand_in();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        n_before = n_out;
        drain(8);
        chk("flush_no_output", 64'(n_out - n_before), 64'd0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_rand_in();
            tick();
        end
        reset = 1'b1;
        set_rand_in();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", 64'(out_result), 64'd0);
        n_before = n_out;
        drain(8);
        chk("reset_no_output", 64'(n_out - n_before), 64'd0);

        // Reset and flush together after a stall.
        for (int i = 0; i < LAT + 1; i++) begin
            in_valid = 1'b1;
            set_rand_in();
            tick();
        end
        out_ready = 1'b0;
        reset     = 1'b1;
        flush     = 1'b1;
        tick();
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rstflush_busy", 64'(busy), 64'd0);
        chk("rstflush_out_tag", 64'(out_tag), 64'd0);
        n_before = n_out;
        drain(8);
        chk("rstflush_no_output", 64'(n_out - n_before), 64'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            set_rand_in();
            tick();
        end
        drain(12);
        chk("random_sb_empty", 64'(q_res.size()), 64'd0);
        chk("random_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_cell_pipe.md
Name: mult_cell_pipe

Overview:
- Parametrised successor to the CPU multiply cell: computes the full 2*DATA_W product of two DATA_W operands.
- Splits each operand into two HALF_W halves and forms four partial products in dedicated multiplier cells.
- Combines the partial products in-block and applies signed/unsigned correction, then returns the low or high word as selected by an op code.
- Sits in the execute/memory path of the soft CPU or a custom-instruction slot; elastic valid/ready pipeline with flush.

Parameters:
- DATA_W, 32, operand and result width; must be even, >= 8.
- HALF_W, DATA_W/2, partial-product slice width (derived, not overridable).
- TAG_W, 5, width of sideband tag carried alongside each operation (e.g. destination register).
- OUT_REG, 1, 1 adds an output register stage (latency 4), 0 drives the result from stage 3 (latency 3).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts a request this cycle.
- in_op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (a signed, b unsigned), 3=MULXSS (high words).
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_tag  in  TAG_W  sideband tag.
- flush  in  1  kill all in-flight operations.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  selected product word.
- out_tag  out  TAG_W  tag of the returned operation.
- busy  out  1  any stage holds a valid operation.

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset clears every stage valid bit. Outputs after reset: out_valid=0, busy=0, in_ready=1, out_result=0, out_tag=0.
- Pipeline: S1 registers a, b, op and tag. S2 registers four HALF_W x HALF_W unsigned products: ll, lh, hl, hh. S3 registers the 2*DATA_W sum ll + (lh+hl)<<HALF_W + hh<<DATA_W plus sign correction. Optional S4 is the output register.
- Sign correction at S3, modulo 2^(2*DATA_W):
  - If op in {MULXSU, MULXSS} and a[MSB]=1, subtract b<<DATA_W.
  - If op=MULXSS and b[MSB]=1, subtract a<<DATA_W.
- Result select: MUL returns product[DATA_W-1:0]; all other ops return product[2*DATA_W-1:DATA_W].
- Latency: 3+OUT_REG cycles from acceptance to out_valid when there is no stall.
- Stall rule: stall = out_valid & ~out_ready.
  - While stalled, all stages hold, including data and tags; this acts as the global enable for every stage.
  - in_ready = ~stall, so bubbles are not squeezed out.
  - An input is accepted iff in_valid & in_ready.
- Output holds stable while out_valid & ~out_ready, and must not change until the handshake completes.
- flush: next cycle all valid bits are 0, out_valid=0, busy=0.
  - Flush overrides a same-cycle accept; the new request is dropped.
  - Flush overrides stall.
- Simultaneous reset and flush: reset wins; the result is identical.
- Datapath registers other than the valid bits need not be reset. The output data register is reset to 0.
- Throughput: one op per cycle when out_ready is held at 1.
- No overflow flag. Arithmetic wraps modulo 2^(2*DATA_W).

Decomposition:
- Shared package mult_cell_pkg holds the op-code enum (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS) and the OP_W=2 constant.
- One natural sub-module: mult_cell_pp, a registered HALF_W x HALF_W unsigned multiplier with enable. It is instantiated four times and maps onto dedicated DSP blocks.
- Stage-control logic (valids, stall, flush) lives in the top module.

Test Plan:
- Reset, then MUL a=0x0000_0003, b=0x0000_0005, out_ready=1 -> out_valid after 4 cycles (OUT_REG=1), result 0x0000_000F, tag echoed.
- MULXSS a=0xFFFF_FFFF (-1), b=0x0000_0002 -> result 0xFFFF_FFFF. MULXUU on the same operands -> 0x0000_0001. MULXSU a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000.
- MUL a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0x0000_0001. MULXUU on the same operands -> 0xFFFF_FFFE.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, results and tags in order.
- Hold out_ready=0 for 5 cycles with a stream pending -> in_ready=0 and out_result/out_tag stable throughout. On release, no loss or duplication.
- Three ops in flight, flush asserted together with in_valid -> next cycle busy=0, out_valid=0, and none of the four ops ever appears. Reset asserted mid-stream -> same outcome.
